approx_rec_mult_pipe: RTL and testbench
=======================================

Name: approx_rec_mult_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width 2x2/4x4/8x8 approximate recursive multipliers.
- Unsigned W x W multiply built recursively from 2x2 base cells, one register stage per recursion level, with valid/ready handshake on both sides.
- The mode is selected per transaction: Kulkarni approximate 2x2 cell (3x3 -> 7) or exact 2x2 cell (3x3 -> 9).
- Sits between operand producers and accumulation/filter datapaths; it replaces the combinational 8-bit instance.

Parameters:
- W, 8: operand width. Power of two, >= 4. Product width is 2W.
- LVL (localparam), log2(W/2): number of combine levels above the 2x2 cells.
- LAT (localparam), LVL+1: cycles from input acceptance to out_valid.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  W  unsigned multiplicand.
- b  in  W  unsigned multiplier.
- approx  in  1  1 = Kulkarni 2x2 cells, 0 = exact 2x2 cells; sampled with a/b.
- out_valid  out  1  Y holds a result.
- out_ready  in  1  consumer accepts Y this cycle.
- Y  out  2W  product.

Behaviour:
- Reset (async assert, sync release): out_valid=0, Y=0, all stage valid bits 0, all pipeline data 0. Assertion mid-operation discards in-flight beats without emitting them.
- Stage 0 registers all (W/2)^2 2x2 cell products. Cell for digit pair (i,j) uses a[2i+1:2i] and b[2j+1:2j], and is weighted by 4^(i+j).
- Approx cell: p0=a0&b0, p1=(a1&b0)|(a0&b1), p2=a1&b1, p3=0. Exact cell: true 4-bit product.
- Stage k (1..LVL) combines groups of four size-n products into size-2n products: LL + (HL<<n) + (LH<<n) + (HH<<2n).
  - HL uses the high half of a with the low half of b; LH uses the low half of a with the high half of b; HH uses both high halves.
  - Each quadrant takes its own correct slice of a and b.
- Adder widths at each level are exactly 2n bits, with no truncation. The approx result is never greater than the exact result, so no overflow occurs.
- Pipeline advance: en = !out_valid | out_ready. All stages shift when en=1 and hold when en=0.
- in_ready = en, driven combinationally from out_valid/out_ready. A beat is accepted when in_valid & in_ready.
- Stage valid bits shift with en. Bubbles propagate as invalid; there is no bubble collapsing.
- Latency is exactly LAT cycles with out_ready held 1; W=8 gives 3. Throughput is 1 beat/cycle.
- Y and out_valid stay stable while out_valid=1 and out_ready=0.
- A simultaneous accept and emit in the same cycle is legal; both occur.
- The approx bit travels with its beat, so a mode change between beats needs no drain.

Optional Feature:
- Macro: ARM_APPROX_HITS_EN.
- Defined: adds output port hits, width 2*log2(W/2)+1, aligned and valid with Y.
  - It counts the 2x2 cells in that beat whose digits are both 3 and approx=1, i.e. cells where an approximation error occurred.
  - Reset value is 0. The count is pipelined through the same stages.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package arm_pkg: function clog2; localparams for the approx/exact mode encodings; a function for the 2x2 cell, usable by the RTL and the bench model.
- One sub-module, arm_cell2: combinational 2x2 cell with mode input, instantiated (W/2)^2 times by generate.
- Combine levels are generate loops in the top module.

Test Plan:
- W=8, approx=1, a=0xFF, b=0xFF -> Y=0xC58F (50575) after 3 cycles; hits=16. Same with approx=0 -> Y=0xFE01, hits=0.
- W=8, approx=1, a=0xF0, b=0x0F -> Y=0x0AF0 (2800); approx=0 -> 0x0E10 (3600). Checks that the HL/LH/HH quadrant slicing is correct.
- W=8, approx=1, a=0xA5, b=0x3C -> Y=0x26AC (9900), equal to exact, hits=0 (no 3x3 digit pairs).
- Backpressure: stream 8 random beats, out_ready=0 for cycles 4-8 -> in_ready falls once the pipe is full, no beat lost or duplicated, Y held stable, order preserved against the package model.
- Reset: assert rst with 2 beats in flight -> out_valid=0 and Y=0 immediately; no stale beat emitted after release.
- W=16, approx=1, a=b=0xFFFF -> Y=0xC71AE38F (3340428175) after 4 cycles; approx=0 -> 0xFFFE0001.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the approximate recursive multiplier: mode encodings,
// a constant-safe clog2 and the 2x2 base-cell function used by RTL and models.
package arm_pkg;

  localparam logic MODE_EXACT  = 1'b0;
  localparam logic MODE_APPROX = 1'b1;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while (((32'd1 << r) < v) && (r < 32)) r++;
    return r;
  endfunction

  // 2x2 digit product; the Kulkarni cell maps 3x3 to 7 and is exact otherwise.
  function automatic logic [3:0] cell2(input logic [1:0] x, input logic [1:0] y,
                                       input logic mode);
    logic [3:0] p;
    p = '0;
    case (mode)
      MODE_APPROX: p = {1'b0, x[1] & y[1], (x[1] & y[0]) | (x[0] & y[1]), x[0] & y[0]};
      MODE_EXACT:  p = 4'(x) * 4'(y);
    endcase
    return p;
  endfunction

endpackage

// File: rtl/arm_cell2.sv
// Combinational 2x2 base cell with per-beat exact/approximate selection.
module arm_cell2
  import arm_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  input  logic       mode_i,
  output logic [3:0] prod_c_o
);

  // Single digit-pair product.
  always_comb prod_c_o = cell2(a_i, b_i, mode_i);

endmodule

// File: rtl/approx_rec_mult_pipe.sv
// Pipelined W x W unsigned approximate recursive multiplier.
// Stage 0 registers every 2x2 cell product; each later stage merges 2x2 groups
// of sub-products into the next operand size. Valid/ready on both sides; the
// whole pipe advances together whenever the output slot is free or drained.
// Optional: define ARM_APPROX_HITS_EN to add the "hits" port, which counts the
// 3x3 digit pairs multiplied in approximate mode for the beat presented on Y.
module approx_rec_mult_pipe
  import arm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           approx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] Y
`ifdef ARM_APPROX_HITS_EN
  ,
  output logic [2*clog2(W/2):0] hits
`endif
);

  localparam int unsigned LVL = clog2(W / 2);
  localparam int unsigned LAT = LVL + 1;
  localparam int unsigned D0  = W / 2;

  logic           en_c;
  logic [LVL:0]   vld_q;
  logic [LVL:0]   vld_d;

  // Global advance: move when the output slot is empty or being consumed.
  always_comb en_c = !out_valid || out_ready;

  assign in_ready  = en_c;
  assign out_valid = vld_q[LVL];

  // Valid bits shift with the data; bubbles stay in place as invalid slots.
  always_comb vld_d = en_c ? {vld_q[LVL-1:0], in_valid} : vld_q;

  // Valid-bit pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  for (genvar k = 0; k <= LVL; k++) begin : g_lvl
    // D blocks per operand at this level, each product PW bits wide.
    localparam int unsigned D  = W >> (k + 1);
    localparam int unsigned PW = 4 << k;

    logic [PW-1:0] p_q [D*D];
    logic [PW-1:0] p_d [D*D];

    if (k == 0) begin : g_cells
      for (genvar i = 0; i < D; i++) begin : g_ai
        for (genvar j = 0; j < D; j++) begin : g_bj
          arm_cell2 u_cell (
            .a_i      (a[2*i +: 2]),
            .b_i      (b[2*j +: 2]),
            .mode_i   (approx),
            .prod_c_o (p_d[i*D + j])
          );
        end
      end
    end else begin : g_comb
      // N is the operand width of the previous level; DP its blocks per side.
      localparam int unsigned N  = 1 << k;
      localparam int unsigned DP = 2 * D;
      for (genvar i = 0; i < D; i++) begin : g_ai
        for (genvar j = 0; j < D; j++) begin : g_bj
          // LL + (HL << N) + (LH << N) + (HH << 2N); HL = high a, low b.
          assign p_d[i*D + j] =
              PW'(g_lvl[k-1].p_q[(2*i)*DP + 2*j])
            + (PW'(g_lvl[k-1].p_q[(2*i+1)*DP + 2*j]) << N)
            + (PW'(g_lvl[k-1].p_q[(2*i)*DP + 2*j + 1]) << N)
            + (PW'(g_lvl[k-1].p_q[(2*i+1)*DP + 2*j + 1]) << (2*N));
        end
      end
    end

    // Stage register for this level's products.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       p_q <= '{default: '0};
      else if (en_c) p_q <= p_d;
    end
  end

  assign Y = g_lvl[LVL].p_q[0];

`ifdef ARM_APPROX_HITS_EN
  localparam int unsigned HW = 2 * LVL + 1;

  logic [D0*D0-1:0] hit_vec_c;
  logic [LAT*HW-1:0] hits_q;
  logic [LAT*HW-1:0] hits_d;

  for (genvar i = 0; i < D0; i++) begin : g_hit_a
    for (genvar j = 0; j < D0; j++) begin : g_hit_b
      assign hit_vec_c[i*D0 + j] = approx && (a[2*i +: 2] == 2'b11) && (b[2*j +: 2] == 2'b11);
    end
  end

  // Hit count enters with the beat and rides the same advance as the data.
  always_comb hits_d = en_c ? {hits_q[(LAT-1)*HW-1:0], HW'($countones(hit_vec_c))} : hits_q;

  // Hit-count pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hits_q <= '0;
    else     hits_q <= hits_d;
  end

  assign hits = hits_q[LAT*HW-1 -: HW];
`endif

endmodule

// File: tb/tb_approx_rec_mult_pipe.sv
// Directed bench for approx_rec_mult_pipe: a W=8 instance for the main scenarios
// and a W=16 instance for the wide case. Hits checks compile with ARM_APPROX_HITS_EN.
module tb_approx_rec_mult_pipe;

  logic clk;
  logic rst;

  logic        in_valid, in_ready, approx, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] Y;

  logic        iv16, ir16, ap16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] y16;

`ifdef ARM_APPROX_HITS_EN
  logic [4:0] hits;
  logic [6:0] hits16;
`endif

  int errors;
  int checks;

  approx_rec_mult_pipe #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx    (approx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y)
`ifdef ARM_APPROX_HITS_EN
    ,
    .hits      (hits)
`endif
  );

  approx_rec_mult_pipe #(.W(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .approx    (ap16),
    .out_valid (ov16),
    .out_ready (or16),
    .Y         (y16)
`ifdef ARM_APPROX_HITS_EN
    ,
    .hits      (hits16)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (Y !== 16'h0000) begin errors++; $display("FAIL reset_Y got=%h exp=0000", Y); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (ov16 !== 1'b0 || y16 !== 32'h0) begin errors++; $display("FAIL reset_w16 got ov=%b y=%h exp ov=0 y=0", ov16, y16); end
`ifdef ARM_APPROX_HITS_EN
    checks++;
    if (hits !== 5'd0) begin errors++; $display("FAIL reset_hits got=%0d exp=0", hits); end
`endif
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", out_valid); end
  endtask

  typedef struct {
    logic [7:0]  va;
    logic [7:0]  vb;
    logic        ap;
    logic [15:0] y;
    logic [4:0]  h;
  } vec_t;

  task automatic test_vectors();
    vec_t v[8];
    int   lat;
    v[0] = '{8'hFF, 8'hFF, 1'b1, 16'hC58F, 5'd16};
    v[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 5'd0};
    v[2] = '{8'hF0, 8'h0F, 1'b1, 16'h0AF0, 5'd4};
    v[3] = '{8'hF0, 8'h0F, 1'b0, 16'h0E10, 5'd0};
    v[4] = '{8'hA5, 8'h3C, 1'b1, 16'h26AC, 5'd0};
    v[5] = '{8'h00, 8'hFF, 1'b1, 16'h0000, 5'd0};
    v[6] = '{8'h03, 8'h03, 1'b1, 16'h0007, 5'd1};
    v[7] = '{8'h0F, 8'hF0, 1'b1, 16'h0AF0, 5'd4};
    out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      a = v[n].va; b = v[n].vb; approx = v[n].ap; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=3", n, lat); end
      checks++;
      if (Y !== v[n].y) begin errors++; $display("FAIL vec%0d_Y got=%h exp=%h", n, Y, v[n].y); end
`ifdef ARM_APPROX_HITS_EN
      checks++;
      if (hits !== v[n].h) begin errors++; $display("FAIL vec%0d_hits got=%0d exp=%0d", n, hits, v[n].h); end
`endif
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  ba[4];
    logic        bp[4];
    logic [15:0] ey[4];
    int k, first_out, last_out;
    ba = '{8'hFF, 8'hFF, 8'h0F, 8'h0F};
    bp = '{1'b1, 1'b0, 1'b1, 1'b0};
    ey = '{16'hC58F, 16'hFE01, 16'h00AF, 16'h00E1};
    k = 0; first_out = -1; last_out = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) begin
        a = ba[c]; b = ba[c]; approx = bp[c]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid) begin
        if (k < 4) begin
          checks++;
          if (Y !== ey[k]) begin errors++; $display("FAIL b2b_Y%0d got=%h exp=%h", k, Y, ey[k]); end
        end
        if (first_out < 0) first_out = c;
        last_out = c;
        k++;
      end
    end
    checks++;
    if (k !== 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", k); end
    checks++;
    if (first_out !== 2 || last_out !== 5) begin
      errors++; $display("FAIL b2b_timing got=%0d..%0d exp=2..5", first_out, last_out);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  pa[8];
    logic [7:0]  pb[8];
    logic        pp[8];
    logic [15:0] ey[8];
    logic [15:0] held_y;
    logic        held, acc;
    int nb, nout, stalls;
    pa = '{8'h12, 8'hFF, 8'h0F, 8'h10, 8'hFF, 8'hF0, 8'h03, 8'h80};
    pb = '{8'h34, 8'hFF, 8'h0F, 8'h10, 8'h01, 8'h0F, 8'h03, 8'h80};
    pp = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    ey = '{16'h03A8, 16'hC58F, 16'h00AF, 16'h0100, 16'h00FF, 16'h0AF0, 16'h0007, 16'h4000};
    nb = 0; nout = 0; stalls = 0; held = 1'b0; held_y = '0;
    for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      if (nb < 8) begin
        a = pa[nb]; b = pb[nb]; approx = pp[nb]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready;
      if (!in_ready) stalls++;
      if (out_valid) begin
        if (held) begin
          checks++;
          if (Y !== held_y) begin errors++; $display("FAIL bp_hold cyc%0d got=%h exp=%h", cyc, Y, held_y); end
        end
        if (out_ready) begin
          checks++;
          if (nout >= 8 || Y !== ey[nout]) begin
            errors++; $display("FAIL bp_Y%0d got=%h exp=%h", nout, Y, (nout < 8) ? ey[nout] : 16'hxxxx);
          end
          nout++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_y = Y;
        end
      end else if (held) begin
        checks++;
        errors++; $display("FAIL bp_valid_drop cyc%0d got=0 exp=1", cyc);
        held = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc) nb++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (nout !== 8) begin errors++; $display("FAIL bp_count got=%0d exp=8", nout); end
    checks++;
    if (stalls !== 5) begin errors++; $display("FAIL bp_stall_cycles got=%0d exp=5", stalls); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    int seen;
    out_ready = 1'b1;
    a = 8'hFF; b = 8'hFF; approx = 1'b0; in_valid = 1'b1;
    tick();
    a = 8'h12; b = 8'h34; approx = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || Y !== 16'hFE01) begin
      errors++; $display("FAIL mid_pre_reset got ov=%b Y=%h exp ov=1 Y=fe01", out_valid, Y);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b exp=0", out_valid); end
    checks++;
    if (Y !== 16'h0000) begin errors++; $display("FAIL mid_reset_Y got=%h exp=0000", Y); end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_stale_beats got=%0d exp=0", seen); end
  endtask

  task automatic test_w16();
    logic [31:0] ey[2];
    int k, first_out;
    ey = '{32'hC71AE38F, 32'hFFFE0001};
    k = 0; first_out = -1;
    or16 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 2) begin
        a16 = 16'hFFFF; b16 = 16'hFFFF; ap16 = (c == 0); iv16 = 1'b1;
      end else begin
        iv16 = 1'b0;
      end
      tick();
      if (ov16) begin
        if (k < 2) begin
          checks++;
          if (y16 !== ey[k]) begin errors++; $display("FAIL w16_Y%0d got=%h exp=%h", k, y16, ey[k]); end
        end
        if (first_out < 0) first_out = c;
        k++;
      end
    end
    checks++;
    if (k !== 2) begin errors++; $display("FAIL w16_count got=%0d exp=2", k); end
    checks++;
    if (first_out !== 3) begin errors++; $display("FAIL w16_latency got=%0d exp=3", first_out); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; approx = 1'b0; a = '0; b = '0;
    iv16 = 1'b0; or16 = 1'b1; ap16 = 1'b0; a16 = '0; b16 = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_w16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
